// File: rtl/clock_monitor.sv
// clock_monitor: brings a slow clock-like input into the clockIn domain,
// emits one-cycle edge pulses, measures the rise-to-rise period, and reports
// whether that period is stable (locked) or has stopped arriving (stalled).
module clock_monitor #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic             clockIn,
    input  logic             reset,
    input  logic             sigIn,
    input  logic             clear,
    output logic             risePulse,
    output logic             fallPulse,
    output logic [CNT_W-1:0] period,
    output logic             periodValid,
    output logic             locked,
    output logic             stalled
);

    localparam int               MC_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [MC_W-1:0]  LOCK_C    = MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        STALL   = 2'd3
    } state_t;

    // Cycle counter increment that parks at TIMEOUT instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= TIMEOUT_C) ? TIMEOUT_C : v + CNT_W'(1);
    endfunction

    // Unsigned distance between two periods; never wraps.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Match counter increment clamped at LOCK_COUNT.
    function automatic logic [MC_W-1:0] sat_match(input logic [MC_W-1:0] v);
        return (v >= LOCK_C) ? LOCK_C : v + MC_W'(1);
    endfunction

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_pulse_d;
    logic             rise_pulse_q;
    logic             fall_pulse_d;
    logic             fall_pulse_q;
    logic [CNT_W-1:0] new_period;
    logic [CNT_W-1:0] period_diff;
    logic             in_tol;
    logic             timeout_hit;
    logic [MC_W-1:0]  match_inc;

    state_t           state_q;
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;
    logic             locked_q;
    logic             stalled_q;
    logic [MC_W-1:0]  match_q;

    // Two-flop synchroniser plus one history flop for edge detection; clear leaves it running.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sigIn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge events, next counter value and the lock/timeout decisions for this cycle.
    always_comb begin
        rise         = sync2_q & ~prev_q;
        fall         = ~sync2_q & prev_q;
        rise_pulse_d = rise & ~clear;
        fall_pulse_d = fall & ~clear;
        if (clear || rise) begin
            cnt_d = '0;
        end else begin
            cnt_d = sat_inc(cnt_q);
        end
        // cnt counts cycles since the last rise, so the rise cycle itself adds one.
        new_period  = cnt_q + CNT_W'(1);
        period_diff = abs_diff(new_period, period_q);
        in_tol      = (period_diff <= TOL_C);
        match_inc   = sat_match(match_q);
        timeout_hit = (cnt_q == TIMEOUT_C - CNT_W'(1));
    end

    // Period counter and registered edge pulses.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
        end
    end

    // Measurement FSM with its registered period, lock and stall outputs.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            stalled_q      <= 1'b0;
            match_q        <= '0;
        end else if (clear) begin
            // A rise seen in this cycle is deliberately dropped.
            state_q        <= IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            stalled_q      <= 1'b0;
            match_q        <= '0;
        end else begin
            period_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    // First period has no predecessor, so no lock comparison yet.
                    if (rise) begin
                        state_q        <= MEASURE;
                        period_q       <= new_period;
                        period_valid_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q   <= STALL;
                        stalled_q <= 1'b1;
                        locked_q  <= 1'b0;
                        match_q   <= '0;
                    end
                end
                MEASURE: begin
                    // A rise on the timeout cycle wins over the stall.
                    if (rise) begin
                        period_q       <= new_period;
                        period_valid_q <= 1'b1;
                        if (in_tol) begin
                            match_q  <= match_inc;
                            locked_q <= (match_inc == LOCK_C);
                        end else begin
                            match_q  <= '0;
                            locked_q <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= STALL;
                        stalled_q <= 1'b1;
                        locked_q  <= 1'b0;
                        match_q   <= '0;
                    end
                end
                STALL: begin
                    // The interval spanning the stall is not a valid period.
                    if (rise) begin
                        state_q   <= ARMED;
                        stalled_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign risePulse   = rise_pulse_q;
    assign fallPulse   = fall_pulse_q;
    assign period      = period_q;
    assign periodValid = period_valid_q;
    assign locked      = locked_q;
    assign stalled     = stalled_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed and randomized stimulus for clock_monitor, checked
// every cycle against an event-level reference model plus scenario checks.
module tb_clock_monitor;

    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 1024;
    localparam int LOCK_COUNT = 4;
    localparam int TOL        = 1;

    logic             clockIn = 1'b0;
    logic             reset   = 1'b1;
    logic             sigIn   = 1'b0;
    logic             clear   = 1'b0;
    logic             risePulse;
    logic             fallPulse;
    logic [CNT_W-1:0] period;
    logic             periodValid;
    logic             locked;
    logic             stalled;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    clock_monitor #(
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT),
        .LOCK_COUNT(LOCK_COUNT),
        .TOL       (TOL)
    ) dut (
        .clockIn    (clockIn),
        .reset      (reset),
        .sigIn      (sigIn),
        .clear      (clear),
        .risePulse  (risePulse),
        .fallPulse  (fallPulse),
        .period     (period),
        .periodValid(periodValid),
        .locked     (locked),
        .stalled    (stalled)
    );

    always #5 clockIn = ~clockIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_word();
        return {11'd0, risePulse, fallPulse, periodValid, locked, stalled, period};
    endfunction

    // Reference model: works on rise event times, not on a cycle counter.
    typedef enum {M_IDLE, M_ARMED, M_MEASURE, M_STALL} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_last_rise = 0;
    int    m_per   = 0;
    int    m_match = 0;
    bit    m_lk = 0, m_st = 0, m_rp = 0, m_fp = 0, m_pv = 0;
    bit    s_hist [4];   // s_hist[i]: sigIn as sampled i posedges ago
    int    n_cyc = 0;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_per = 0; m_match = 0;
        m_lk = 0; m_st = 0; m_rp = 0; m_fp = 0; m_pv = 0;
        for (int i = 0; i < 4; i++) s_hist[i] = 1'b0;
        m_last_rise = n_cyc;
    endtask

    task automatic model_step(input bit sig, input bit clr);
        bit rise, fall;
        int gap, d;
        for (int i = 3; i > 0; i--) s_hist[i] = s_hist[i-1];
        s_hist[0] = sig;
        // A level sampled at edge k shows up as a pulse after edge k+2.
        rise = s_hist[2] & ~s_hist[3];
        fall = ~s_hist[2] & s_hist[3];
        gap  = n_cyc - m_last_rise;
        m_pv = 0;
        if (clr) begin
            m_mode = M_IDLE;
            m_per = 0; m_match = 0;
            m_lk = 0; m_st = 0; m_rp = 0; m_fp = 0;
        end else begin
            m_rp = rise;
            m_fp = fall;
            if (rise) begin
                case (m_mode)
                    M_IDLE:  m_mode = M_ARMED;
                    M_ARMED: begin m_mode = M_MEASURE; m_per = gap; m_pv = 1; end
                    M_MEASURE: begin
                        d = (gap > m_per) ? gap - m_per : m_per - gap;
                        if (d <= TOL) begin
                            m_match = (m_match + 1 > LOCK_COUNT) ? LOCK_COUNT : m_match + 1;
                            m_lk = (m_match >= LOCK_COUNT);
                        end else begin
                            m_match = 0; m_lk = 0;
                        end
                        m_per = gap; m_pv = 1;
                    end
                    default: begin m_mode = M_ARMED; m_st = 0; end
                endcase
                m_last_rise = n_cyc;
            end else if ((m_mode == M_ARMED || m_mode == M_MEASURE) && gap == TIMEOUT) begin
                m_mode = M_STALL; m_st = 1; m_lk = 0; m_match = 0;
            end
        end
    endtask

    // Observation records of DUT behaviour, used by scenario checks.
    int pv_count = 0, rp_count = 0;
    int last_rp_cyc = 0, last_fp_cyc = 0;
    int stall_rise_cyc = 0, stall_fall_cyc = 0, lock_pv_idx = -1;
    bit stall_prev = 0, lock_prev = 0;

    // Per-cycle monitor: advance the model at each posedge, compare just after it.
    initial begin
        bit s_sig, s_clr, s_rst;
        forever begin
            @(posedge clockIn);
            s_sig = sigIn; s_clr = clear; s_rst = reset;
            n_cyc++;
            if (!s_rst) model_reset();
            else model_step(s_sig, s_clr);
            #1;
            chk("cycle", dut_word(),
                {11'd0, m_rp, m_fp, m_pv, m_lk, m_st, 16'(m_per)});
            if (periodValid === 1'b1) pv_count++;
            if (risePulse === 1'b1) begin rp_count++; last_rp_cyc = n_cyc; end
            if (fallPulse === 1'b1) last_fp_cyc = n_cyc;
            if (stalled === 1'b1 && !stall_prev) stall_rise_cyc = n_cyc;
            if (stalled !== 1'b1 && stall_prev) stall_fall_cyc = n_cyc;
            stall_prev = (stalled === 1'b1);
            if (locked === 1'b1 && !lock_prev) lock_pv_idx = pv_count;
            lock_prev = (locked === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wave(input int hi, input int lo);
        sigIn = 1'b1;
        repeat (hi) @(negedge clockIn);
        sigIn = 1'b0;
        repeat (lo) @(negedge clockIn);
    endtask

    initial begin
        int base, rbase, lat, hi, lo, cap;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        model_reset();
        #1 chk("reset_async_idle", dut_word(), 32'd0);
        repeat (3) @(negedge clockIn);
        reset = 1'b1;
        repeat (2) @(negedge clockIn);

        // Divide-by-64 input: period 64, lock on 5th periodValid
        pv_count = 0;
        repeat (7) wave(32, 32);
        repeat (4) @(negedge clockIn);
        chk("t1_pv_count", pv_count, 6);
        chk("t1_lock_at_pv", lock_pv_idx, 5);
        chk("t1_period", period, 64);
        chk("t1_locked", locked, 1);
        chk("t1_stalled", stalled, 0);

        // Gaps 64,64,64,64,65,64 then 66 breaks lock
        clear = 1'b1;
        @(negedge clockIn);
        clear = 1'b0;
        chk("t2_clear_period", period, 0);
        wave(32, 32); wave(32, 32); wave(32, 32); wave(32, 32);
        wave(32, 33); wave(32, 32); wave(32, 34);
        chk("t2_locked_before", locked, 1);
        chk("t2_period_before", period, 64);
        wave(32, 32);
        chk("t2_locked_after", locked, 0);
        chk("t2_period_after", period, 66);

        // Lock, then hold low until stall, then restart
        repeat (6) wave(32, 32);
        chk("t3_locked", locked, 1);
        repeat (1100) @(negedge clockIn);
        chk("t3_stalled", stalled, 1);
        chk("t3_unlocked", locked, 0);
        chk("t3_stall_delay", stall_rise_cyc - last_rp_cyc, TIMEOUT);
        base = pv_count;
        wave(32, 32);
        chk("t3_unstall", stalled, 0);
        chk("t3_unstall_at_rise", stall_fall_cyc, last_rp_cyc);
        chk("t3_no_pv_first", pv_count, base);
        wave(32, 32);
        chk("t3_pv_second", pv_count, base + 1);
        chk("t3_period", period, 64);

        // Reset between clock edges while measuring
        wave(32, 10);
        #2 reset = 1'b0;
        model_reset();
        #1 chk("t4_reset_async", dut_word(), 32'd0);
        repeat (3) @(negedge clockIn);
        reset = 1'b1;
        base = pv_count;
        wave(32, 32);
        chk("t4_no_pv_first", pv_count, base);
        wave(32, 32);
        chk("t4_pv_second", pv_count, base + 1);
        wave(32, 32);

        // Clear in the cycle the rise is detected
        rbase = rp_count;
        sigIn = 1'b1;
        @(negedge clockIn);
        @(negedge clockIn);
        clear = 1'b1;
        @(negedge clockIn);
        clear = 1'b0;
        chk("t5_rise_dropped", risePulse, 0);
        chk("t5_no_pv", periodValid, 0);
        chk("t5_period_zero", period, 0);
        repeat (29) @(negedge clockIn);
        sigIn = 1'b0;
        repeat (32) @(negedge clockIn);
        chk("t5_rise_count", rp_count, rbase);
        base = pv_count;
        wave(32, 32);
        chk("t5_armed_no_pv", pv_count, base);
        wave(32, 32);
        chk("t5_pv_after", pv_count, base + 1);

        // Latency and 50% duty pulse spacing
        sigIn = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(posedge clockIn);
            #1 lat++;
            if (risePulse === 1'b1) break;
        end
        chk("t6_latency", lat, 3);
        @(negedge clockIn);
        repeat (29) @(negedge clockIn);
        sigIn = 1'b0;
        repeat (32) @(negedge clockIn);
        chk("t6_fall_spacing", last_fp_cyc - last_rp_cyc, 32);

        // Randomized jittered stream with occasional clears
        repeat (40) begin
            hi = int'($urandom_range(20, 40));
            lo = 63 - hi + int'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) begin
                clear = 1'b1;
                @(negedge clockIn);
                clear = 1'b0;
            end
            wave(hi, lo);
        end

        // Boundary: gap of exactly TIMEOUT is a period, TIMEOUT+1 stalls
        repeat (3) wave(32, 32);
        wave(32, TIMEOUT - 32);
        wave(32, 32);
        chk("b_period_timeout", period, TIMEOUT);
        chk("b_no_stall", stalled, 0);
        wave(32, TIMEOUT - 31);
        cap = last_rp_cyc;
        base = pv_count;
        wave(32, 32);
        chk("b_stall_delay", stall_rise_cyc - cap, TIMEOUT);
        chk("b_unstalled", stalled, 0);
        chk("b_no_pv_after_stall", pv_count, base);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
